fetch_seq: RTL and testbench

FETCH_SEQ -- requirements
Module: fetch_seq

---
 rtl/fetch_seq.sv | 114 +++++++++++
 tb/tb_fetch_seq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// Instruction fetch/execute sequencer: FETCH -> EXEC0 -> (EXEC1) -> FETCH, owning PC, IR and carry.
// Optional single-step gating is compiled in with `define SEQ_STEP_EN.
module fetch_seq (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ack,
   input  logic [7:0]  imem_data,
   output logic [7:0]  inst,
   output logic        cycle,
   output logic        carry,
   output logic        valid,
   input  logic        MC,
   input  logic        J,
   input  logic        LJ,
   input  logic [15:0] jtarget,
   input  logic        WC,
   input  logic        alu_cout,
`ifdef SEQ_STEP_EN
   input  logic        step,
`endif
   input  logic        mem_done
);

   typedef enum logic [1:0] {StFetch, StExec0, StExec1} state_e;

   state_e      r_state;
   logic        r_req;
   logic [15:0] r_pc;
   logic [7:0]  r_inst;
   logic        r_cycle;
   logic        r_carry;
`ifdef SEQ_STEP_EN
   logic        r_hold;
`endif

   logic w_accept;
   logic w_valid;
   logic w_done;

   // An ack only counts while our own request is visible, so stale acks are dropped.
   assign w_accept = (r_state == StFetch) && r_req && imem_ack;
   assign w_valid  = (r_state == StExec0) || ((r_state == StExec1) && mem_done);
   assign w_done   = ((r_state == StExec0) && !MC) || ((r_state == StExec1) && mem_done);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StFetch;
         r_req   <= 1'b0;
         r_pc    <= 16'h0000;
         r_inst  <= 8'h00;
         r_cycle <= 1'b0;
         r_carry <= 1'b0;
`ifdef SEQ_STEP_EN
         r_hold  <= 1'b0;
`endif
      end else begin
         case (r_state)
            StFetch: begin
               if (w_accept) begin
                  r_inst  <= imem_data;
                  r_pc    <= r_pc + 16'd1;
                  r_req   <= 1'b0;
                  r_cycle <= 1'b0;
                  r_state <= StExec0;
               end else if (!r_req) begin
`ifdef SEQ_STEP_EN
                  if (!r_hold || step) begin
                     r_req  <= 1'b1;
                     r_hold <= 1'b0;
                  end
`else
                  r_req <= 1'b1;
`endif
               end
            end
            StExec0: begin
               if (MC) begin
                  r_cycle <= 1'b1;
                  r_state <= StExec1;
               end else begin
                  r_state <= StFetch;
               end
            end
            StExec1: begin
               if (mem_done) r_state <= StFetch;
            end
            default: r_state <= StFetch;
         endcase

         // Later assignment overrides the increment made on accept.
         if (w_valid && (J || LJ)) r_pc <= jtarget;
         if (w_valid && WC) r_carry <= alu_cout;

         // Request the next fetch on the completing edge so there is no idle bubble.
         if (w_done) begin
`ifdef SEQ_STEP_EN
            r_hold <= 1'b1;
`else
            r_req  <= 1'b1;
`endif
         end
      end
   end

   assign imem_req  = r_req;
   assign imem_addr = r_pc;
   assign inst      = r_inst;
   assign cycle     = r_cycle;
   assign carry     = r_carry;
   assign valid     = w_valid;

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: directed vector table, reset corner case, then random
// instructions checked against a transaction-level model of PC, IR and carry.
module tb_fetch_seq;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [7:0]  imem_data;
   logic [7:0]  inst;
   logic        cycle;
   logic        carry;
   logic        valid;
   logic        MC;
   logic        J;
   logic        LJ;
   logic [15:0] jtarget;
   logic        WC;
   logic        alu_cout;
   logic        mem_done;
`ifdef SEQ_STEP_EN
   logic        step;
`endif

   fetch_seq u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .imem_req  (imem_req),
      .imem_addr (imem_addr),
      .imem_ack  (imem_ack),
      .imem_data (imem_data),
      .inst      (inst),
      .cycle     (cycle),
      .carry     (carry),
      .valid     (valid),
      .MC        (MC),
      .J         (J),
      .LJ        (LJ),
      .jtarget   (jtarget),
      .WC        (WC),
      .alu_cout  (alu_cout),
`ifdef SEQ_STEP_EN
      .step      (step),
`endif
      .mem_done  (mem_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests;
   int n_fail;

   // Architectural model: what the sequencer should hold between instructions.
   logic [15:0] m_pc;
   logic        m_carry;
   logic [7:0]  m_inst;

   typedef struct {
      int          ack_dly;
      logic [7:0]  data;
      logic        mc;
      int          done_dly;
      logic        j;
      logic        lj;
      logic        wc;
      logic [15:0] jt;
      logic        cout;
      logic [15:0] exp_pc;
      logic        exp_c;
   } vec_t;

   vec_t tab[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctl();
      imem_ack = 1'b0;
      MC       = 1'b0;
      J        = 1'b0;
      LJ       = 1'b0;
      WC       = 1'b0;
      alu_cout = 1'b0;
      jtarget  = 16'h0000;
      mem_done = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req"},   imem_req,  0);
      chk({tag, "_addr"},  imem_addr, 0);
      chk({tag, "_inst"},  inst,      0);
      chk({tag, "_cycle"}, cycle,     0);
      chk({tag, "_carry"}, carry,     0);
      chk({tag, "_valid"}, valid,     0);
   endtask

   task automatic run_instr(input int ack_dly, input logic [7:0] d, input logic mc,
                            input int done_dly, input logic j, input logic lj, input logic wc,
                            input logic [15:0] jt, input logic cout);
      int k;
      k = 0;
      while (!imem_req && k < 10) begin
         tick();
         k++;
      end
      chk("req_wait", imem_req, 1);
      chk("fetch_addr", imem_addr, m_pc);
      chk("fetch_valid", valid, 0);
      for (int i = 0; i < ack_dly; i++) begin
         imem_ack  = 1'b0;
         imem_data = 8'($urandom);
         tick();
         chk("req_hold", imem_req, 1);
         chk("inst_hold", inst, m_inst);
         chk("wait_valid", valid, 0);
      end
      imem_ack  = 1'b1;
      imem_data = d;
      tick();
      imem_ack  = 1'($urandom);
      imem_data = 8'($urandom);
      m_pc   = m_pc + 16'd1;
      m_inst = d;
      chk("ex0_inst", inst, d);
      chk("ex0_cycle", cycle, 0);
      chk("ex0_req", imem_req, 0);
      chk("ex0_pc_inc", imem_addr, m_pc);
      MC = mc;
      if (!mc) begin
         J = j; LJ = lj; WC = wc; jtarget = jt; alu_cout = cout;
      end
      #1;
      chk("ex0_valid", valid, 1);
      if (mc) begin
         tick();
         MC = 1'($urandom);
         for (int i = 0; i < done_dly; i++) begin
            mem_done = 1'b0;
            J        = 1'($urandom);
            LJ       = 1'($urandom);
            WC       = 1'b1;
            alu_cout = ~m_carry;
            jtarget  = 16'($urandom);
            imem_ack = 1'($urandom);
            #1;
            chk("ex1_cycle", cycle, 1);
            chk("ex1_wait_valid", valid, 0);
            chk("ex1_carry_hold", carry, m_carry);
            chk("ex1_pc_hold", imem_addr, m_pc);
            tick();
         end
         chk("ex1_carry_pre", carry, m_carry);
         mem_done = 1'b1;
         J = j; LJ = lj; WC = wc; jtarget = jt; alu_cout = cout;
         #1;
         chk("ex1_valid", valid, 1);
         chk("ex1_done_cycle", cycle, 1);
      end
      if (j || lj) m_pc = jt;
      if (wc) m_carry = cout;
      tick();
      clear_ctl();
      #1;
      chk("next_addr", imem_addr, m_pc);
      chk("next_carry", carry, m_carry);
      chk("next_inst", inst, d);
      chk("next_cycle", cycle, mc);
      chk("next_valid", valid, 0);
`ifdef SEQ_STEP_EN
      chk("step_hold_req", imem_req, 0);
      tick();
      tick();
      chk("no_step_no_fetch", imem_req, 0);
      step = 1'b1;
      tick();
      step = 1'b0;
`else
      chk("next_req", imem_req, 1);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      n_tests = 0;
      n_fail  = 0;
      m_pc    = 16'h0000;
      m_carry = 1'b0;
      m_inst  = 8'h00;
      rst_n   = 1'b0;
      imem_data = 8'h00;
      clear_ctl();
`ifdef SEQ_STEP_EN
      step = 1'b0;
`endif
      //          ack data   mc  dd  j     lj    wc    jt        cout  exp_pc    exp_c
      tab[0] = '{1, 8'h41, 1'b0, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b0};
      tab[1] = '{0, 8'h9A, 1'b1, 2, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b0};
      tab[2] = '{2, 8'h13, 1'b0, 0, 1'b1, 1'b0, 1'b1, 16'h1234, 1'b1, 16'h1234, 1'b1};
      tab[3] = '{0, 8'h27, 1'b1, 0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0};
      tab[4] = '{1, 8'h55, 1'b0, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
      tab[5] = '{0, 8'h66, 1'b1, 1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0001, 1'b1};

      tick();
      tick();
      chk_reset_vals("rst");
      rst_n = 1'b1;
      tick();
      chk("req_after_rst", imem_req, 1);

      foreach (tab[i]) begin
         run_instr(tab[i].ack_dly, tab[i].data, tab[i].mc, tab[i].done_dly, tab[i].j,
                   tab[i].lj, tab[i].wc, tab[i].jt, tab[i].cout);
         chk($sformatf("vec%0d_pc", i), imem_addr, tab[i].exp_pc);
         chk($sformatf("vec%0d_carry", i), carry, tab[i].exp_c);
      end

      // Reset while EXEC1 waits on memory, with pending jump/carry and a stray ack.
      k = 0;
      while (!imem_req && k < 10) begin
         tick();
         k++;
      end
      chk("rst_seq_req", imem_req, 1);
      imem_ack  = 1'b1;
      imem_data = 8'hC3;
      tick();
      imem_ack = 1'b0;
      MC       = 1'b1;
      tick();
      mem_done = 1'b0;
      J        = 1'b1;
      jtarget  = 16'hBEEF;
      WC       = 1'b1;
      alu_cout = ~carry;
      #1;
      chk("rst_seq_ex1", cycle, 1);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("rst_mid");
      imem_ack = 1'b1;
      mem_done = 1'b1;
      tick();
      chk_reset_vals("rst_hold");
      rst_n = 1'b1;
      J  = 1'b0;
      WC = 1'b0;
      mem_done = 1'b0;
      MC = 1'b0;
      tick();
      chk("stray_req_rise", imem_req, 1);
      chk("stray_ack_inst", inst, 0);
      chk("stray_ack_pc", imem_addr, 0);
      imem_ack = 1'b0;
      tick();
      chk("stray_ack_req", imem_req, 1);
      chk("stray_ack_inst2", inst, 0);
      m_pc    = 16'h0000;
      m_carry = 1'b0;
      m_inst  = 8'h00;

      for (int n = 0; n < 40; n++) begin
         logic [15:0] jt;
         jt = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
         run_instr(int'($urandom_range(0, 3)), 8'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) == 0), 1'($urandom), jt, 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
